// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET at the
// retire boundary, updates trap CSRs and redirects fetch.
//
// state | meaning
// IDLE  | waiting for exception / interrupt / mret
// ENTER | strobe trap-entry CSR writes, compute trap target
// EXIT  | strobe mret CSR writes, target is mepc
// REDIR | hold redirect until fetch accepts it
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            exc_valid,
  input  logic [XLEN-2:0] exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_npc,
  input  logic            mret_valid,
  input  logic            irq_sw,
  input  logic            irq_tm,
  input  logic            irq_ext,
  input  logic            csr_rd_mstatus_mie,
  input  logic            csr_rd_mstatus_mpie,
  input  logic            csr_rd_mie_msie,
  input  logic            csr_rd_mie_mtie,
  input  logic            csr_rd_mie_meie,
  input  logic [XLEN-3:0] csr_rd_mtvec_base,
  input  logic [1:0]      csr_rd_mtvec_mode,
  input  logic [XLEN-1:0] csr_rd_mepc_mepc,
  output logic            ent_trap,
  output logic            ext_trap,
  output logic            csr_wr_mstatus_mie,
  output logic            csr_wr_mstatus_mpie,
  output logic [XLEN-1:0] csr_wr_mepc_mepc,
  output logic [XLEN-1:0] csr_wr_mtval_mtval,
  output logic [XLEN-2:0] csr_wr_mcause_exception_code,
  output logic            csr_wr_mcause_interrupt,
  output logic            csr_set_mip_msip,
  output logic            csr_set_mip_mtip,
  output logic            csr_set_mip_meip,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ENTER, EXIT, REDIR} state_t;

  state_t          state;
  logic [XLEN-2:0] cause_q;
  logic            intr_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            mei, msi, mti;
  logic            int_take;
  logic            accept;
  logic [XLEN-2:0] int_cause;
  logic [XLEN-1:0] base_addr;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] target;

  always_comb begin
    mei       = irq_ext & csr_rd_mie_meie;
    msi       = irq_sw & csr_rd_mie_msie;
    mti       = irq_tm & csr_rd_mie_mtie;
    int_take  = retire_valid & csr_rd_mstatus_mie & (mei | msi | mti);
    accept    = exc_valid | int_take | mret_valid;
    int_cause = mei ? (XLEN-1)'(11) : (msi ? (XLEN-1)'(3) : (XLEN-1)'(7));
    base_addr = {csr_rd_mtvec_base, 2'b00};
    // top cause bit falls off the 4*cause product, which wraps mod 2^XLEN anyway
    vec_off   = {cause_q[XLEN-3:0], 2'b00};
    target    = (csr_rd_mtvec_mode == 2'd1 && intr_q) ? base_addr + vec_off : base_addr;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      cause_q       <= '0;
      intr_q        <= 1'b0;
      epc_q         <= '0;
      tval_q        <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_valid) begin
            cause_q <= exc_code;
            intr_q  <= 1'b0;
            epc_q   <= exc_pc;
            tval_q  <= exc_tval;
            state   <= ENTER;
          end else if (int_take) begin
            cause_q <= int_cause;
            intr_q  <= 1'b1;
            epc_q   <= retire_npc;
            tval_q  <= '0;
            state   <= ENTER;
          end else if (mret_valid) begin
            state <= EXIT;
          end
        end
        ENTER: begin
          redirect_pc_q <= target;
          state         <= REDIR;
        end
        EXIT: begin
          redirect_pc_q <= csr_rd_mepc_mepc;
          state         <= REDIR;
        end
        REDIR: begin
          if (redirect_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ent_trap                     = (state == ENTER);
    ext_trap                     = (state == EXIT);
    redirect_valid               = (state == REDIR);
    busy                         = (state != IDLE);
    // accept-cycle flush is gated so a pending event cannot flush during reset
    flush                        = busy | (accept & rst_b);
    redirect_pc                  = redirect_pc_q;
    csr_wr_mstatus_mie           = (state == EXIT) ? csr_rd_mstatus_mpie : 1'b0;
    csr_wr_mstatus_mpie          = (state == EXIT) ? 1'b1 : csr_rd_mstatus_mie;
    csr_wr_mepc_mepc             = epc_q;
    csr_wr_mtval_mtval           = tval_q;
    csr_wr_mcause_exception_code = cause_q;
    csr_wr_mcause_interrupt      = intr_q;
    csr_set_mip_msip             = irq_sw;
    csr_set_mip_mtip             = irq_tm;
    csr_set_mip_meip             = irq_ext;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expectations are queued when stimulus is
// driven and popped against DUT outputs at each sample point.
module tb_trap_ctrl;
  localparam int XLEN = 32;

  logic            clk, rst_b;
  logic            exc_valid, retire_valid, mret_valid;
  logic [XLEN-2:0] exc_code;
  logic [XLEN-1:0] exc_pc, exc_tval, retire_npc;
  logic            irq_sw, irq_tm, irq_ext;
  logic            rd_mie, rd_mpie, rd_msie, rd_mtie, rd_meie;
  logic [XLEN-3:0] rd_base;
  logic [1:0]      rd_mode;
  logic [XLEN-1:0] rd_mepc;
  logic            ent_trap, ext_trap, wr_mie, wr_mpie;
  logic [XLEN-1:0] wr_mepc, wr_mtval;
  logic [XLEN-2:0] wr_code;
  logic            wr_intr, set_msip, set_mtip, set_meip;
  logic            redirect_valid, redirect_ready, flush, busy;
  logic [XLEN-1:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;
  string       tags[$];
  logic [31:0] vals[$];

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_b(rst_b),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .retire_valid(retire_valid), .retire_npc(retire_npc), .mret_valid(mret_valid),
    .irq_sw(irq_sw), .irq_tm(irq_tm), .irq_ext(irq_ext),
    .csr_rd_mstatus_mie(rd_mie), .csr_rd_mstatus_mpie(rd_mpie),
    .csr_rd_mie_msie(rd_msie), .csr_rd_mie_mtie(rd_mtie), .csr_rd_mie_meie(rd_meie),
    .csr_rd_mtvec_base(rd_base), .csr_rd_mtvec_mode(rd_mode), .csr_rd_mepc_mepc(rd_mepc),
    .ent_trap(ent_trap), .ext_trap(ext_trap),
    .csr_wr_mstatus_mie(wr_mie), .csr_wr_mstatus_mpie(wr_mpie),
    .csr_wr_mepc_mepc(wr_mepc), .csr_wr_mtval_mtval(wr_mtval),
    .csr_wr_mcause_exception_code(wr_code), .csr_wr_mcause_interrupt(wr_intr),
    .csr_set_mip_msip(set_msip), .csr_set_mip_mtip(set_mtip), .csr_set_mip_meip(set_meip),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp(input string tag, input logic [31:0] val);
    tags.push_back(tag);
    vals.push_back(val);
  endtask

  task automatic got(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (vals.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: observed %h expected none", obs);
      $error("scoreboard empty, observed %h", obs);
      return;
    end
    t = tags.pop_front();
    e = vals.pop_front();
    assert (obs === e) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", t, obs, e);
      $error("%s observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; exc_valid = 1'b0; retire_valid = 1'b0; mret_valid = 1'b0;
    exc_code = '0; exc_pc = '0; exc_tval = '0; retire_npc = '0;
    irq_sw = 1'b0; irq_tm = 1'b0; irq_ext = 1'b0;
    rd_mie = 1'b0; rd_mpie = 1'b0; rd_msie = 1'b0; rd_mtie = 1'b0; rd_meie = 1'b0;
    rd_base = '0; rd_mode = 2'd0; rd_mepc = '0; redirect_ready = 1'b0;

    // reset state, with an exception request pending during reset
    exc_valid = 1'b1;
    exp("rst_busy", 0); exp("rst_ent", 0); exp("rst_ext", 0); exp("rst_rv", 0);
    exp("rst_flush", 0); exp("rst_rpc", 0); exp("rst_mepc", 0); exp("rst_code", 0);
    #12;
    got(busy); got(ent_trap); got(ext_trap); got(redirect_valid);
    got(flush); got(redirect_pc); got(wr_mepc); got(wr_code);
    exc_valid = 1'b0;
    rst_b = 1'b1;
    cyc();

    // synchronous exception, direct mode
    rd_base = 30'h200; rd_mode = 2'd0; rd_mie = 1'b1; rd_mpie = 1'b0;
    exc_code = 31'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD; exc_valid = 1'b1;
    exp("t1_flush", 1); exp("t1_busy_idle", 0);
    exp("t1_ent", 1); exp("t1_mepc", 32'h100); exp("t1_code", 2); exp("t1_intr", 0);
    exp("t1_mtval", 32'hDEAD); exp("t1_wr_mie", 0); exp("t1_wr_mpie", 1); exp("t1_ext", 0);
    exp("t1_rv", 1); exp("t1_rpc", 32'h800); exp("t1_redir_flush", 1); exp("t1_ent_off", 0);
    exp("t1_idle_busy", 0);
    #1; got(flush); got(busy);
    cyc(); exc_valid = 1'b0;
    got(ent_trap); got(wr_mepc); got(wr_code); got(wr_intr);
    got(wr_mtval); got(wr_mie); got(wr_mpie); got(ext_trap);
    cyc();
    got(redirect_valid); got(redirect_pc); got(flush); got(ent_trap);
    redirect_ready = 1'b1;
    cyc(); redirect_ready = 1'b0;
    got(busy);

    // vectored interrupt, MEI beats MTI, then 5-cycle redirect stall
    rd_mode = 2'd1; rd_meie = 1'b1; rd_mtie = 1'b1; rd_msie = 1'b0;
    irq_tm = 1'b1; irq_ext = 1'b1; retire_npc = 32'h44; retire_valid = 1'b1;
    exp("t2_flush", 1); exp("t2_meip", 1); exp("t2_mtip", 1); exp("t2_msip", 0);
    exp("t2_ent", 1); exp("t2_code", 11); exp("t2_intr", 1); exp("t2_mepc", 32'h44); exp("t2_mtval", 0);
    for (int i = 0; i < 5; i++) begin
      exp("t2_stall_rv", 1); exp("t2_stall_rpc", 32'h82C); exp("t2_stall_busy", 1);
    end
    exp("t2_idle_busy", 0); exp("t2_no_reentry", 0);
    #1; got(flush); got(set_meip); got(set_mtip); got(set_msip);
    cyc(); retire_valid = 1'b0; irq_tm = 1'b0; irq_ext = 1'b0;
    got(ent_trap); got(wr_code); got(wr_intr); got(wr_mepc); got(wr_mtval);
    cyc();
    for (int i = 0; i < 5; i++) begin
      exc_valid = (i == 2);
      exc_code = 31'd4; exc_pc = 32'h500;
      #1;
      got(redirect_valid); got(redirect_pc); got(busy);
      cyc();
    end
    exc_valid = 1'b0;
    redirect_ready = 1'b1;
    cyc(); redirect_ready = 1'b0;
    got(busy);
    cyc();
    got(ent_trap);

    // MRET
    rd_mepc = 32'h44; rd_mpie = 1'b1; rd_mie = 1'b0; mret_valid = 1'b1;
    exp("t3_flush", 1); exp("t3_ext", 1); exp("t3_ent", 0); exp("t3_wr_mie", 1); exp("t3_wr_mpie", 1);
    exp("t3_rpc", 32'h44); exp("t3_rv", 1); exp("t3_ext_off", 0);
    #1; got(flush);
    cyc(); mret_valid = 1'b0;
    got(ext_trap); got(ent_trap); got(wr_mie); got(wr_mpie);
    cyc();
    got(redirect_pc); got(redirect_valid); got(ext_trap);
    redirect_ready = 1'b1;
    cyc(); redirect_ready = 1'b0;

    // exception and interrupt together: exception wins, interrupt follows
    rd_mie = 1'b1; rd_msie = 1'b1; rd_meie = 1'b0; rd_mtie = 1'b0; rd_mode = 2'd1;
    irq_sw = 1'b1; retire_valid = 1'b1; retire_npc = 32'h60;
    exc_valid = 1'b1; exc_code = 31'd5; exc_pc = 32'h300; exc_tval = 32'h7;
    exp("t4_flush", 1); exp("t4_msip", 1);
    exp("t4_intr_exc", 0); exp("t4_code_exc", 5); exp("t4_mepc_exc", 32'h300); exp("t4_rpc_exc", 32'h800);
    exp("t4_idle_busy", 0); exp("t4_int_flush", 1);
    exp("t4_intr_int", 1); exp("t4_code_int", 3); exp("t4_mepc_int", 32'h88); exp("t4_rpc_int", 32'h80C);
    #1; got(flush); got(set_msip);
    cyc(); exc_valid = 1'b0;
    got(wr_intr); got(wr_code); got(wr_mepc);
    cyc();
    got(redirect_pc);
    retire_npc = 32'h88; redirect_ready = 1'b1;
    cyc();
    got(busy); got(flush);
    cyc(); retire_valid = 1'b0; irq_sw = 1'b0;
    got(wr_intr); got(wr_code); got(wr_mepc);
    cyc();
    got(redirect_pc);
    cyc(); redirect_ready = 1'b0;

    // reset asserted while in REDIR
    rd_mode = 2'd0; exc_code = 31'd1; exc_pc = 32'h10; exc_valid = 1'b1;
    exp("t5_rv_before", 1); exp("t5_rv_rst", 0); exp("t5_flush_rst", 0); exp("t5_busy_rst", 0);
    for (int i = 0; i < 3; i++) begin
      exp("t5_ent_after", 0); exp("t5_ext_after", 0);
    end
    exp("t5_rpc_cleared", 0);
    cyc(); exc_valid = 1'b0;
    cyc();
    got(redirect_valid);
    rst_b = 1'b0;
    #1; got(redirect_valid); got(flush); got(busy);
    cyc(); rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      got(ent_trap); got(ext_trap);
    end
    got(redirect_pc);

    n_cmp++;
    assert (vals.size() == 0) else begin
      n_err++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", vals.size());
      $error("scoreboard leftover %0d", vals.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
